// File: rtl/sdio_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module      : sdio_cmd_engine
// Description : SD CMD-line engine. Serialises a 48-bit command with CRC7 and
//               optionally captures a 48/136-bit response with Ncr timeout and
//               Ncc turnaround. Define SDIO_CMD_CRC_CHK_EN for response CRC7.
// Revision    : 1.0 - initial release
// ============================================================================
module sdio_cmd_engine #(
    parameter int NCR_MAX = 64,
    parameter int NCC     = 8,
    parameter int RESP_W  = 136
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdio_clk,
    input  logic              sdio_cmd_i,
    output logic              sdio_cmd_o,
    output logic              sdio_cmd_oen,
    input  logic              i_en,
    input  logic [5:0]        i_cmd,
    input  logic [31:0]       i_para,
    input  logic [1:0]        i_resp_type,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout,
    output logic              o_crc_err,
    output logic [RESP_W-1:0] o_resp
);

    localparam int c_MAX_A   = (NCR_MAX > NCC) ? NCR_MAX : NCC;
    localparam int c_CNT_MAX = (c_MAX_A > 136) ? c_MAX_A : 136;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_NCR_LAST     = c_CNT_W'(NCR_MAX - 1);
    localparam logic [c_CNT_W-1:0] c_NCC_LAST     = c_CNT_W'(NCC - 1);
    localparam logic [c_CNT_W-1:0] c_TX_CRC_START = c_CNT_W'(40);
    localparam logic [c_CNT_W-1:0] c_TX_END_BIT   = c_CNT_W'(47);
    localparam logic [c_CNT_W-1:0] c_SHORT_LAST   = c_CNT_W'(47);
    localparam logic [c_CNT_W-1:0] c_LONG_LAST    = c_CNT_W'(135);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_TX      = 3'd1;
    localparam logic [2:0] c_ST_RX_WAIT = 3'd2;
    localparam logic [2:0] c_ST_RX      = 3'd3;
    localparam logic [2:0] c_ST_NCC     = 3'd4;

    logic [2:0]         r_state;
    logic               r_sclk_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic [39:0]        r_tx_sr;
    logic [6:0]         r_tx_crc;
    logic [1:0]         r_resp_type;
    logic               r_cmd_o;
    logic               r_cmd_oen;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout;
    logic [RESP_W-1:0]  r_resp;

    logic w_rise;
    logic w_fall;
    logic w_accept;
    logic w_rx_last;

    assign w_rise    = sdio_clk & ~r_sclk_q;
    assign w_fall    = ~sdio_clk & r_sclk_q;
    assign w_accept  = (r_state == c_ST_IDLE) & i_en & ~r_busy;
    assign w_rx_last = (r_resp_type == 2'd3) ? (r_cnt == c_LONG_LAST) : (r_cnt == c_SHORT_LAST);

    // Serial CRC7 step, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] f_crc7_next(input logic [6:0] crc, input logic din);
        return {crc[5:3], crc[2] ^ din ^ crc[6], crc[1:0], din ^ crc[6]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_sclk_q    <= 1'b0;
            r_cnt       <= '0;
            r_tx_sr     <= '0;
            r_tx_crc    <= '0;
            r_resp_type <= 2'd0;
            r_cmd_o     <= 1'b1;
            r_cmd_oen   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_resp      <= '0;
        end else begin
            r_sclk_q <= sdio_clk;
            r_done   <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_tx_sr     <= {2'b01, i_cmd, i_para};
                        r_tx_crc    <= '0;
                        r_resp_type <= i_resp_type;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_timeout   <= 1'b0;
                        r_resp      <= '0;
                        r_state     <= c_ST_TX;
                    end
                end
                c_ST_TX: begin
                    if (w_fall) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt < c_TX_CRC_START) begin
                            r_cmd_oen <= 1'b1;
                            r_cmd_o   <= r_tx_sr[39];
                            r_tx_sr   <= {r_tx_sr[38:0], 1'b0};
                            r_tx_crc  <= f_crc7_next(r_tx_crc, r_tx_sr[39]);
                        end else if (r_cnt < c_TX_END_BIT) begin
                            r_cmd_o  <= r_tx_crc[6];
                            r_tx_crc <= {r_tx_crc[5:0], 1'b0};
                        end else if (r_cnt == c_TX_END_BIT) begin
                            r_cmd_o <= 1'b1;
                        end else begin
                            // End bit has been held a full period: release the line.
                            r_cmd_oen <= 1'b0;
                            r_cmd_o   <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= (r_resp_type == 2'd0) ? c_ST_NCC : c_ST_RX_WAIT;
                        end
                    end
                end
                c_ST_RX_WAIT: begin
                    if (w_rise) begin
                        // r_resp is already zero, so the start bit needs no shift.
                        if (!sdio_cmd_i) begin
                            r_cnt   <= c_CNT_W'(1);
                            r_state <= c_ST_RX;
                        end else if (r_cnt == c_NCR_LAST) begin
                            r_timeout <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= c_ST_NCC;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_ST_RX: begin
                    if (w_rise) begin
                        r_resp <= {r_resp[RESP_W-2:0], sdio_cmd_i};
                        if (w_rx_last) begin
                            r_cnt   <= '0;
                            r_state <= c_ST_NCC;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_ST_NCC: begin
                    if (w_rise) begin
                        if (r_cnt == c_NCC_LAST) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

`ifdef SDIO_CMD_CRC_CHK_EN
    localparam logic [c_CNT_W-1:0] c_CRC_LO_LONG  = c_CNT_W'(8);
    localparam logic [c_CNT_W-1:0] c_CRC_HI_LONG  = c_CNT_W'(128);
    localparam logic [c_CNT_W-1:0] c_CRC_HI_SHORT = c_CNT_W'(40);

    logic [6:0] r_rx_crc;
    logic       r_crc_bad;
    logic       r_crc_err;
    logic       w_rx_crc_in;

    // Long responses exclude the start/dir/reserved byte from the CRC.
    assign w_rx_crc_in = (r_resp_type == 2'd3) ? ((r_cnt >= c_CRC_LO_LONG) && (r_cnt < c_CRC_HI_LONG))
                                               : (r_cnt < c_CRC_HI_SHORT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_crc  <= '0;
            r_crc_bad <= 1'b0;
            r_crc_err <= 1'b0;
        end else if (w_accept) begin
            r_rx_crc  <= '0;
            r_crc_bad <= 1'b0;
            r_crc_err <= 1'b0;
        end else begin
            if ((r_state == c_ST_RX) && w_rise) begin
                if (w_rx_crc_in) begin
                    r_rx_crc <= f_crc7_next(r_rx_crc, sdio_cmd_i);
                end
                // On the final bit, received bits 7..1 sit in r_resp[6:0].
                if (w_rx_last) begin
                    r_crc_bad <= (r_resp_type != 2'd2) && (r_rx_crc != r_resp[6:0]);
                end
            end
            if ((r_state == c_ST_NCC) && w_rise && (r_cnt == c_NCC_LAST)) begin
                r_crc_err <= r_crc_bad;
            end
        end
    end

    assign o_crc_err = r_crc_err;
`else
    assign o_crc_err = 1'b0;
`endif

    assign sdio_cmd_o   = r_cmd_o;
    assign sdio_cmd_oen = r_cmd_oen;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_timeout    = r_timeout;
    assign o_resp       = r_resp;

endmodule
`default_nettype wire
